// File: rtl/regfile_mp_if.sv
// Register-file port bundle: read ports, EX/MEM write-back, issue and the busy scoreboard.
// Latency: reads are combinational, writes land on the next edge; there is no backpressure.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
    logic [NUM_RD*DATA_W-1:0] rd_data_o;
    logic [NUM_RD-1:0]        rd_busy_o;
    logic                     ex_wb_en_i;
    logic [ADDR_W-1:0]        ex_rd_i;
    logic [DATA_W-1:0]        ex_rd_data_i;
    logic                     mem_wb_en_i;
    logic [ADDR_W-1:0]        mem_rd_i;
    logic [DATA_W-1:0]        mem_rd_data_i;
    logic                     iss_en_i;
    logic [ADDR_W-1:0]        iss_rd_i;
    logic [ADDR_W:0]          busy_cnt_o;

    modport slave (
        input  rd_addr_i, ex_wb_en_i, ex_rd_i, ex_rd_data_i,
               mem_wb_en_i, mem_rd_i, mem_rd_data_i, iss_en_i, iss_rd_i,
        output rd_data_o, rd_busy_o, busy_cnt_o
    );

    modport master (
        output rd_addr_i, ex_wb_en_i, ex_rd_i, ex_rd_data_i,
               mem_wb_en_i, mem_rd_i, mem_rd_data_i, iss_en_i, iss_rd_i,
        input  rd_data_o, rd_busy_o, busy_cnt_o
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read, dual-write-back register file with bypass, hard-wired x0 and a busy scoreboard.
// Latency: reads are combinational, writes land on the next edge; there is no backpressure (ID stalls on rd_busy_o).
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic         clk,
    input  logic         rest,
    regfile_mp_if.slave  bus
);
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;

    logic ex_we, mem_we;

    // On a same-address collision EX carries the younger result, so MEM is dropped.
    assign ex_we  = bus.ex_wb_en_i && (bus.ex_rd_i != '0);
    assign mem_we = bus.mem_wb_en_i && (bus.mem_rd_i != '0) &&
                    !(bus.ex_wb_en_i && (bus.ex_rd_i == bus.mem_rd_i));

    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (bus.iss_en_i && (bus.iss_rd_i == ADDR_W'(r))) begin
                busy_d[r] = 1'b1;
            end else if ((bus.ex_wb_en_i  && (bus.ex_rd_i  == ADDR_W'(r))) ||
                         (bus.mem_wb_en_i && (bus.mem_rd_i == ADDR_W'(r)))) begin
                busy_d[r] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;

        // Incremental count keeps the output registered without a full popcount.
        cnt_d = cnt_q;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (busy_d[r] && !busy_q[r]) begin
                cnt_d = cnt_d + CNT_ONE;
            end else if (!busy_d[r] && busy_q[r]) begin
                cnt_d = cnt_d - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (ex_we) begin
                regs_q[bus.ex_rd_i] <= bus.ex_rd_data_i;
            end
            if (mem_we) begin
                regs_q[bus.mem_rd_i] <= bus.mem_rd_data_i;
            end
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    logic [NUM_RD*DATA_W-1:0] rd_data_w;
    logic [NUM_RD-1:0]        rd_busy_w;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              ex_hit, mem_hit;
        logic [DATA_W-1:0] rd_dat;

        assign addr    = bus.rd_addr_i[k*ADDR_W +: ADDR_W];
        assign ex_hit  = bus.ex_wb_en_i  && (bus.ex_rd_i  == addr);
        assign mem_hit = bus.mem_wb_en_i && (bus.mem_rd_i == addr);

        always_comb begin
            if (rest || (addr == '0)) begin
                rd_dat = '0;
            end else if (ex_hit) begin
                rd_dat = bus.ex_rd_data_i;
            end else if (mem_hit) begin
                rd_dat = bus.mem_rd_data_i;
            end else begin
                rd_dat = regs_q[addr];
            end
        end

        assign rd_data_w[k*DATA_W +: DATA_W] = rd_dat;
        // A value arriving on a write-back port this cycle is forwarded, so the operand is ready.
        assign rd_busy_w[k] = busy_q[addr] && !ex_hit && !mem_hit && (addr != '0) && !rest;
    end

    assign bus.rd_data_o  = rd_data_w;
    assign bus.rd_busy_o  = rd_busy_w;
    assign bus.busy_cnt_o = cnt_q;
endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    localparam int K_DATA = 0;
    localparam int K_BUSY = 1;
    localparam int K_CNT  = 2;

    logic clk = 1'b0;
    logic rest;

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk  (clk),
        .rest (rest),
        .bus  (bus)
    );

    int              kind_q [$];
    int              port_q [$];
    logic [DW-1:0]   exp_q  [$];
    string           tag_q  [$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic push(int kind, int port, logic [DW-1:0] e, string tag);
        kind_q.push_back(kind);
        port_q.push_back(port);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic exp_rd(int port, logic [DW-1:0] e, string tag);
        push(K_DATA, port, e, tag);
    endtask

    task automatic exp_busy(int port, logic e, string tag);
        push(K_BUSY, port, {{(DW-1){1'b0}}, e}, tag);
    endtask

    task automatic exp_cnt(int e, string tag);
        push(K_CNT, 0, DW'(e), tag);
    endtask

    task automatic check_all();
        while (exp_q.size() > 0) begin
            int            k;
            int            p;
            logic [DW-1:0] e;
            logic [DW-1:0] o;
            string         t;
            k = kind_q.pop_front();
            p = port_q.pop_front();
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            case (k)
                K_DATA:  o = bus.rd_data_o[p*DW +: DW];
                K_BUSY:  o = {{(DW-1){1'b0}}, bus.rd_busy_o[p]};
                default: o = DW'(bus.busy_cnt_o);
            endcase
            vectors++;
            assert (o === e) else begin
                miscompares++;
                $error("FAIL %s: observed 0x%0h expected 0x%0h", t, o, e);
            end
        end
    endtask

    // Outputs settle mid-cycle and are checked on the falling edge; state then commits.
    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ex_wb_en_i    = 1'b0;
        bus.ex_rd_i       = '0;
        bus.ex_rd_data_i  = '0;
        bus.mem_wb_en_i   = 1'b0;
        bus.mem_rd_i      = '0;
        bus.mem_rd_data_i = '0;
        bus.iss_en_i      = 1'b0;
        bus.iss_rd_i      = '0;
    endtask

    task automatic ex_wr(int a, logic [DW-1:0] d, logic en);
        bus.ex_wb_en_i   = en;
        bus.ex_rd_i      = AW'(a);
        bus.ex_rd_data_i = d;
    endtask

    task automatic mem_wr(int a, logic [DW-1:0] d, logic en);
        bus.mem_wb_en_i   = en;
        bus.mem_rd_i      = AW'(a);
        bus.mem_rd_data_i = d;
    endtask

    task automatic iss(int a);
        bus.iss_en_i = 1'b1;
        bus.iss_rd_i = AW'(a);
    endtask

    task automatic rda(int p, int a);
        bus.rd_addr_i[p*AW +: AW] = AW'(a);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rest = 1'b1;
        bus.rd_addr_i = '0;
        idle();
        rda(0, 5);
        exp_rd(0, 32'h0, "init_rd_rst");
        exp_busy(0, 1'b0, "init_busy_rst");
        step();

        // Reset sequence: load x5, reset, confirm cleared
        rest = 1'b0;
        exp_cnt(0, "rst_cnt0");
        ex_wr(5, 32'h1234, 1'b1);
        exp_rd(0, 32'h1234, "x5_bypass");
        step();
        idle();
        exp_rd(0, 32'h1234, "x5_stored");
        step();
        rest = 1'b1;
        exp_rd(0, 32'h0, "x5_during_rst");
        exp_busy(0, 1'b0, "busy_during_rst");
        step();
        rest = 1'b0;
        exp_rd(0, 32'h0, "x5_after_rst");
        exp_cnt(0, "cnt_after_rst");
        step();

        // Bypass gating on both write-back ports
        rda(0, 3);
        ex_wr(3, 32'h11, 1'b1);
        step();
        ex_wr(3, 32'hAAAA, 1'b0);
        exp_rd(0, 32'h11, "ex_gated_off");
        step();
        ex_wr(3, 32'hAAAA, 1'b1);
        exp_rd(0, 32'hAAAA, "ex_bypass_on");
        step();
        idle();
        exp_rd(0, 32'hAAAA, "ex_stored");
        mem_wr(3, 32'h5555, 1'b0);
        step();
        mem_wr(3, 32'h5555, 1'b1);
        exp_rd(0, 32'h5555, "mem_bypass_on");
        step();
        idle();
        exp_rd(0, 32'h5555, "mem_stored");
        step();

        // Dual write: same address EX wins, different addresses both land
        rda(0, 7);
        rda(1, 8);
        ex_wr(7, 32'h1, 1'b1);
        mem_wr(7, 32'h2, 1'b1);
        exp_rd(0, 32'h1, "conflict_bypass");
        step();
        idle();
        exp_rd(0, 32'h1, "conflict_stored");
        exp_rd(1, 32'h0, "x8_untouched");
        step();
        ex_wr(7, 32'h3, 1'b1);
        mem_wr(8, 32'h2, 1'b1);
        exp_rd(0, 32'h3, "dual_x7_bypass");
        exp_rd(1, 32'h2, "dual_x8_bypass");
        step();
        idle();
        exp_rd(0, 32'h3, "dual_x7_stored");
        exp_rd(1, 32'h2, "dual_x8_stored");
        step();

        // Zero register
        rda(0, 0);
        rda(1, 0);
        ex_wr(0, 32'hFFFF_FFFF, 1'b1);
        mem_wr(0, 32'hFFFF_FFFF, 1'b1);
        iss(0);
        exp_rd(0, 32'h0, "x0_rd_during_wr");
        exp_busy(0, 1'b0, "x0_busy_during_wr");
        step();
        idle();
        exp_rd(1, 32'h0, "x0_rd_after");
        exp_busy(1, 1'b0, "x0_busy_after");
        exp_cnt(0, "x0_cnt_after");
        step();

        // Scoreboard on x9
        rda(0, 9);
        iss(9);
        exp_busy(0, 1'b0, "x9_busy_issue_cyc");
        exp_cnt(0, "x9_cnt_issue_cyc");
        step();
        idle();
        exp_busy(0, 1'b1, "x9_busy");
        exp_cnt(1, "x9_cnt1");
        step();
        ex_wr(9, 32'h99, 1'b1);
        iss(9);
        exp_busy(0, 1'b0, "x9_fwd_ready");
        exp_rd(0, 32'h99, "x9_fwd_data");
        exp_cnt(1, "x9_cnt_wr_iss");
        step();
        idle();
        exp_busy(0, 1'b1, "x9_reissued_busy");
        exp_cnt(1, "x9_cnt_held");
        exp_rd(0, 32'h99, "x9_stored");
        step();
        mem_wr(9, 32'h77, 1'b1);
        exp_busy(0, 1'b0, "x9_mem_fwd_ready");
        exp_rd(0, 32'h77, "x9_mem_fwd_data");
        exp_cnt(1, "x9_cnt_before_clear");
        step();
        idle();
        exp_busy(0, 1'b0, "x9_cleared");
        exp_cnt(0, "x9_cnt0");
        exp_rd(0, 32'h77, "x9_mem_stored");
        step();

        // Count: two issues then a double clear in one cycle
        rda(0, 1);
        rda(1, 2);
        iss(1);
        exp_cnt(0, "cnt_start");
        step();
        idle();
        iss(2);
        exp_cnt(1, "cnt_one");
        exp_busy(0, 1'b1, "x1_busy");
        step();
        idle();
        ex_wr(1, 32'h10, 1'b1);
        mem_wr(2, 32'h20, 1'b1);
        exp_cnt(2, "cnt_two");
        exp_busy(0, 1'b0, "x1_fwd_ready");
        exp_busy(1, 1'b0, "x2_fwd_ready");
        step();
        idle();
        exp_cnt(0, "cnt_zero");
        exp_busy(0, 1'b0, "x1_cleared");
        exp_busy(1, 1'b0, "x2_cleared");
        step();

        // Reset discards same-cycle writes and issues
        rda(0, 4);
        iss(10);
        step();
        idle();
        exp_cnt(1, "x10_cnt_pre_rst");
        rest = 1'b1;
        iss(4);
        ex_wr(4, 32'hBEEF, 1'b1);
        exp_rd(0, 32'h0, "rst_blocks_bypass");
        exp_busy(0, 1'b0, "rst_blocks_busy");
        step();
        rest = 1'b0;
        idle();
        exp_rd(0, 32'h0, "rst_dropped_write");
        exp_busy(0, 1'b0, "rst_dropped_issue");
        exp_cnt(0, "rst_cnt_cleared");
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
